// File: rtl/typ_pkg.sv
// Shared types and widths for the I2C responder slice.
package typ_pkg;

    localparam int I2C_ADDR_W = 7;
    localparam int I2C_DATA_W = 8;

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        WR_BYTE,
        WR_ACK,
        RD_LOAD,
        RD_BYTE,
        RD_ACK,
        IGNORE
    } i2c_rsp_state_t;

    typedef enum logic {
        WRITE = 1'b0,
        READ  = 1'b1
    } i2c_op_t;

endpackage

// File: rtl/i2c_line_sync.sv
// Brings SCL/SDA into the clock domain and turns line transitions into
// single-cycle START, STOP, SCL-rise and SCL-fall events.
module i2c_line_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic scl,
    input  logic sda,
    output logic sda_level,
    output logic start_det,
    output logic stop_det,
    output logic scl_rise,
    output logic scl_fall
);

    logic [SYNC_STAGES-1:0] scl_sync;
    logic [SYNC_STAGES-1:0] sda_sync;
    logic                   scl_dly;
    logic                   sda_dly;
    logic                   scl_level;

    // Synchronizer chains plus one delay flop; reset to the idle-bus level so no event fires out of reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_dly  <= 1'b1;
            sda_dly  <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda};
            scl_dly  <= scl_sync[SYNC_STAGES-1];
            sda_dly  <= sda_sync[SYNC_STAGES-1];
        end
    end

    assign scl_level = scl_sync[SYNC_STAGES-1];
    assign sda_level = sda_sync[SYNC_STAGES-1];

    // SDA transitions only count as bus conditions while SCL stays high across both samples
    assign start_det = scl_level & scl_dly & sda_dly & ~sda_level;
    assign stop_det  = scl_level & scl_dly & ~sda_dly & sda_level;
    assign scl_rise  = scl_level & ~scl_dly;
    assign scl_fall  = ~scl_level & scl_dly;

endmodule

// File: rtl/i2c_slave_responder.sv
// I2C target: address match, write delivery and read serving over ready/valid.
// SDA is only ever pulled low; SCL is never driven and never stretched.
module i2c_slave_responder
    import typ_pkg::*;
#(
    parameter logic [I2C_ADDR_W-1:0] SLAVE_ADDR  = 7'h22,
    parameter int                    SYNC_STAGES = 2,
    parameter int                    HOLD_CYCLES = 4,
    parameter logic [I2C_DATA_W-1:0] IDLE_BYTE   = 8'hFF
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  scl_i,
    input  logic                  sda_i,
    output logic                  sda_oe_o,
    output logic                  start_o,
    output logic                  stop_o,
    output logic                  addr_hit_o,
    output logic                  rw_o,
    output logic [I2C_DATA_W-1:0] rx_data_o,
    output logic                  rx_valid_o,
    input  logic [I2C_DATA_W-1:0] tx_data_i,
    input  logic                  tx_valid_i,
    output logic                  tx_ready_o,
    output logic                  underrun_o,
    output logic                  mst_nack_o,
    output logic                  busy_o
);

    logic sda_level;
    logic start_det;
    logic stop_det;
    logic scl_rise;
    logic scl_fall;

    i2c_line_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_line_sync (
        .clk      (clk_i),
        .rst_n    (rst_i),
        .scl      (scl_i),
        .sda      (sda_i),
        .sda_level(sda_level),
        .start_det(start_det),
        .stop_det (stop_det),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall)
    );

    i2c_rsp_state_t          state_q, state_d;
    logic [I2C_ADDR_W-1:0]   shift_q, shift_d;
    logic [2:0]              bit_cnt_q, bit_cnt_d;
    logic [3:0]              hold_cnt_q;
    logic                    hold_exp;
    logic                    sda_oe_q, sda_oe_d;
    i2c_op_t                 rw_q, rw_d;
    logic [I2C_DATA_W-1:0]   rx_data_q, rx_data_d;
    logic [I2C_DATA_W-2:0]   tx_shift_q, tx_shift_d;
    logic                    busy_q, busy_d;
    logic                    ack_seen_q, ack_seen_d;
    logic                    start_p_q, start_p_d;
    logic                    stop_p_q, stop_p_d;
    logic                    hit_p_q, hit_p_d;
    logic                    rxv_p_q, rxv_p_d;
    logic                    nack_p_q, nack_p_d;
    logic                    tx_ready;
    logic                    underrun;
    logic [I2C_DATA_W-1:0]   tx_byte;

    assign tx_byte  = tx_valid_i ? tx_data_i : IDLE_BYTE;
    assign hold_exp = (hold_cnt_q == 4'd1);

    // Hold timer: every SCL fall restarts it, and SDA may only change on the cycle it expires
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            hold_cnt_q <= 4'd0;
        end else if (scl_fall) begin
            hold_cnt_q <= 4'(HOLD_CYCLES);
        end else if (hold_cnt_q != 4'd0) begin
            hold_cnt_q <= hold_cnt_q - 4'd1;
        end
    end

    // Next-state and datapath logic; START/STOP override whatever the FSM was doing
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        sda_oe_d   = sda_oe_q;
        rw_d       = rw_q;
        rx_data_d  = rx_data_q;
        tx_shift_d = tx_shift_q;
        busy_d     = busy_q;
        ack_seen_d = ack_seen_q;
        start_p_d  = 1'b0;
        stop_p_d   = 1'b0;
        hit_p_d    = 1'b0;
        rxv_p_d    = 1'b0;
        nack_p_d   = 1'b0;
        tx_ready   = 1'b0;
        underrun   = 1'b0;

        if (stop_det) begin
            state_d    = IDLE;
            stop_p_d   = 1'b1;
            busy_d     = 1'b0;
            rw_d       = WRITE;
            sda_oe_d   = 1'b0;
            bit_cnt_d  = 3'd0;
            ack_seen_d = 1'b0;
        end else if (start_det) begin
            state_d    = ADDR;
            start_p_d  = 1'b1;
            busy_d     = 1'b1;
            rw_d       = WRITE;
            sda_oe_d   = 1'b0;
            bit_cnt_d  = 3'd0;
            ack_seen_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    sda_oe_d = 1'b0;
                end
                ADDR: begin
                    if (scl_rise) begin
                        shift_d   = {shift_q[I2C_ADDR_W-2:0], sda_level};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            if (shift_q == SLAVE_ADDR) begin
                                state_d = ADDR_ACK;
                                hit_p_d = 1'b1;
                                rw_d    = i2c_op_t'(sda_level);
                            end else begin
                                state_d = IGNORE;
                            end
                        end
                    end
                end
                ADDR_ACK, WR_ACK: begin
                    if (hold_exp) begin
                        if (!sda_oe_q) begin
                            sda_oe_d = 1'b1;
                        end else begin
                            sda_oe_d = 1'b0;
                            if (state_q == ADDR_ACK && rw_q == READ) begin
                                state_d = RD_LOAD;
                            end else begin
                                state_d = WR_BYTE;
                            end
                        end
                    end
                end
                WR_BYTE: begin
                    if (scl_rise) begin
                        shift_d   = {shift_q[I2C_ADDR_W-2:0], sda_level};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            rx_data_d = {shift_q, sda_level};
                            rxv_p_d   = 1'b1;
                            state_d   = WR_ACK;
                        end
                    end
                end
                RD_LOAD: begin
                    tx_ready   = 1'b1;
                    underrun   = ~tx_valid_i;
                    sda_oe_d   = ~tx_byte[I2C_DATA_W-1];
                    tx_shift_d = tx_byte[I2C_DATA_W-2:0];
                    bit_cnt_d  = 3'd0;
                    state_d    = RD_BYTE;
                end
                RD_BYTE: begin
                    if (scl_rise) begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                    if (hold_exp) begin
                        if (bit_cnt_q == 3'd0) begin
                            sda_oe_d = 1'b0;
                            state_d  = RD_ACK;
                        end else begin
                            sda_oe_d   = ~tx_shift_q[I2C_DATA_W-2];
                            tx_shift_d = {tx_shift_q[I2C_DATA_W-3:0], 1'b0};
                        end
                    end
                end
                RD_ACK: begin
                    sda_oe_d = 1'b0;
                    if (scl_rise) begin
                        if (sda_level) begin
                            nack_p_d = 1'b1;
                            state_d  = IGNORE;
                        end else begin
                            ack_seen_d = 1'b1;
                        end
                    end else if (hold_exp && ack_seen_q) begin
                        ack_seen_d = 1'b0;
                        state_d    = RD_LOAD;
                    end
                end
                IGNORE: begin
                    sda_oe_d = 1'b0;
                end
                default: begin
                    state_d  = IDLE;
                    sda_oe_d = 1'b0;
                end
            endcase
        end
    end

    // State and datapath registers, all cleared to an idle, released bus on reset
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            bit_cnt_q  <= 3'd0;
            sda_oe_q   <= 1'b0;
            rw_q       <= WRITE;
            rx_data_q  <= '0;
            tx_shift_q <= '0;
            busy_q     <= 1'b0;
            ack_seen_q <= 1'b0;
            start_p_q  <= 1'b0;
            stop_p_q   <= 1'b0;
            hit_p_q    <= 1'b0;
            rxv_p_q    <= 1'b0;
            nack_p_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            sda_oe_q   <= sda_oe_d;
            rw_q       <= rw_d;
            rx_data_q  <= rx_data_d;
            tx_shift_q <= tx_shift_d;
            busy_q     <= busy_d;
            ack_seen_q <= ack_seen_d;
            start_p_q  <= start_p_d;
            stop_p_q   <= stop_p_d;
            hit_p_q    <= hit_p_d;
            rxv_p_q    <= rxv_p_d;
            nack_p_q   <= nack_p_d;
        end
    end

    assign sda_oe_o   = sda_oe_q;
    assign start_o    = start_p_q;
    assign stop_o     = stop_p_q;
    assign addr_hit_o = hit_p_q;
    assign rw_o       = (rw_q == READ);
    assign rx_data_o  = rx_data_q;
    assign rx_valid_o = rxv_p_q;
    assign tx_ready_o = tx_ready;
    assign underrun_o = underrun;
    assign mst_nack_o = nack_p_q;
    assign busy_o     = busy_q;

endmodule

// File: tb/tb_i2c_slave_responder.sv
// Directed bench: a behavioural I2C master drives the responder and
// observed bus data and host-side pulses are compared to hand-computed values.
module tb_i2c_slave_responder;

    localparam int Q = 200;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       scl_m;
    logic       sda_m;
    logic       scl_i;
    logic       sda_i;
    logic       sda_oe_o;
    logic       start_o;
    logic       stop_o;
    logic       addr_hit_o;
    logic       rw_o;
    logic [7:0] rx_data_o;
    logic       rx_valid_o;
    logic [7:0] tx_data_i;
    logic       tx_valid_i;
    logic       tx_ready_o;
    logic       underrun_o;
    logic       mst_nack_o;
    logic       busy_o;

    int n_checks = 0;
    int n_fail   = 0;

    int n_start = 0;
    int n_stop  = 0;
    int n_hit   = 0;
    int n_txr   = 0;
    int n_und   = 0;
    int n_nack  = 0;
    int n_oe    = 0;
    logic       hit_rw = 1'b0;
    logic [7:0] rx_log[$];
    logic [7:0] tx_q[$];
    int         tx_ptr = 0;

    i2c_slave_responder dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .scl_i     (scl_i),
        .sda_i     (sda_i),
        .sda_oe_o  (sda_oe_o),
        .start_o   (start_o),
        .stop_o    (stop_o),
        .addr_hit_o(addr_hit_o),
        .rw_o      (rw_o),
        .rx_data_o (rx_data_o),
        .rx_valid_o(rx_valid_o),
        .tx_data_i (tx_data_i),
        .tx_valid_i(tx_valid_i),
        .tx_ready_o(tx_ready_o),
        .underrun_o(underrun_o),
        .mst_nack_o(mst_nack_o),
        .busy_o    (busy_o)
    );

    always #5 clk_i = ~clk_i;

    // Open-drain bus: either side pulling low wins
    assign scl_i = scl_m;
    assign sda_i = sda_m & ~sda_oe_o;

    // Host-side tx source fed from a queue the stimulus fills
    always_comb begin
        tx_valid_i = (tx_ptr < tx_q.size());
        tx_data_i  = tx_valid_i ? tx_q[tx_ptr] : 8'h00;
    end

    // Consume on the same edge the responder captures tx_data_i
    always @(posedge clk_i) begin
        if (tx_ready_o && tx_valid_i) tx_ptr <= tx_ptr + 1;
    end

    // Pulse monitor sampled mid-cycle
    always @(negedge clk_i) begin
        if (start_o)    n_start <= n_start + 1;
        if (stop_o)     n_stop  <= n_stop + 1;
        if (addr_hit_o) begin
            n_hit  <= n_hit + 1;
            hit_rw <= rw_o;
        end
        if (rx_valid_o) rx_log.push_back(rx_data_o);
        if (tx_ready_o) n_txr   <= n_txr + 1;
        if (underrun_o) n_und   <= n_und + 1;
        if (mst_nack_o) n_nack  <= n_nack + 1;
        if (sda_oe_o)   n_oe    <= n_oe + 1;
    end

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic bus_bit(input logic b, output logic r);
        #Q sda_m = b;
        #Q scl_m = 1'b1;
        #Q r = sda_i;
        #Q scl_m = 1'b0;
    endtask

    task automatic bus_start();
        #Q sda_m = 1'b1;
        #Q scl_m = 1'b1;
        #Q sda_m = 1'b0;
        #Q scl_m = 1'b0;
    endtask

    task automatic bus_stop();
        #Q sda_m = 1'b0;
        #Q scl_m = 1'b1;
        #Q sda_m = 1'b1;
        #Q;
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack_bit);
        logic r;
        for (int i = 7; i >= 0; i--) bus_bit(d[i], r);
        bus_bit(1'b1, ack_bit);
    endtask

    task automatic read_byte(input logic mack, output logic [7:0] d);
        logic r;
        d = 8'h00;
        for (int i = 0; i < 8; i++) begin
            bus_bit(1'b1, r);
            d = {d[6:0], r};
        end
        bus_bit(mack, r);
    endtask

    initial begin
        logic       ack;
        logic [7:0] rd;
        int b_start, b_stop, b_hit, b_rx, b_txr, b_und, b_nack, b_oe, b_ptr;

        rst_i = 1'b0;
        scl_m = 1'b1;
        sda_m = 1'b1;
        repeat (3) @(negedge clk_i);
        check_output("rst_sda_oe", 32'(sda_oe_o), 32'd0);
        check_output("rst_busy", 32'(busy_o), 32'd0);
        check_output("rst_rx_data", 32'(rx_data_o), 32'h00);
        check_output("rst_rw", 32'(rw_o), 32'd0);
        check_output("rst_pulses", 32'({start_o, stop_o, addr_hit_o, rx_valid_o, tx_ready_o, underrun_o, mst_nack_o}), 32'd0);
        rst_i = 1'b1;
        repeat (5) @(negedge clk_i);

        // Write 0x22: 00, 7F, FF
        $display("[TB] write 0x22 three bytes");
        b_start = n_start; b_stop = n_stop; b_hit = n_hit; b_rx = rx_log.size();
        bus_start();
        write_byte(8'h44, ack);
        check_output("wr_addr_ack", 32'(ack), 32'd0);
        check_output("wr_busy", 32'(busy_o), 32'd1);
        check_output("wr_hit_cnt", 32'(n_hit - b_hit), 32'd1);
        check_output("wr_hit_rw", 32'(hit_rw), 32'd0);
        write_byte(8'h00, ack);
        check_output("wr_ack0", 32'(ack), 32'd0);
        write_byte(8'h7F, ack);
        check_output("wr_ack1", 32'(ack), 32'd0);
        write_byte(8'hFF, ack);
        check_output("wr_ack2", 32'(ack), 32'd0);
        bus_stop();
        repeat (10) @(negedge clk_i);
        check_output("wr_rx_cnt", 32'(rx_log.size() - b_rx), 32'd3);
        check_output("wr_rx0", 32'(rx_log[b_rx]), 32'h00);
        check_output("wr_rx1", 32'(rx_log[b_rx+1]), 32'h7F);
        check_output("wr_rx2", 32'(rx_log[b_rx+2]), 32'hFF);
        check_output("wr_start_cnt", 32'(n_start - b_start), 32'd1);
        check_output("wr_stop_cnt", 32'(n_stop - b_stop), 32'd1);
        check_output("wr_busy_end", 32'(busy_o), 32'd0);

        // Read 0x22: A5 (ACK), 3C (NACK)
        $display("[TB] read 0x22 two bytes");
        tx_q.push_back(8'hA5);
        tx_q.push_back(8'h3C);
        b_txr = n_txr; b_nack = n_nack; b_und = n_und; b_hit = n_hit;
        bus_start();
        write_byte(8'h45, ack);
        check_output("rd_addr_ack", 32'(ack), 32'd0);
        check_output("rd_hit_cnt", 32'(n_hit - b_hit), 32'd1);
        check_output("rd_hit_rw", 32'(hit_rw), 32'd1);
        read_byte(1'b0, rd);
        check_output("rd_byte0", 32'(rd), 32'hA5);
        read_byte(1'b1, rd);
        check_output("rd_byte1", 32'(rd), 32'h3C);
        repeat (10) @(negedge clk_i);
        check_output("rd_sda_rel", 32'(sda_oe_o), 32'd0);
        bus_stop();
        repeat (10) @(negedge clk_i);
        check_output("rd_txr_cnt", 32'(n_txr - b_txr), 32'd2);
        check_output("rd_nack_cnt", 32'(n_nack - b_nack), 32'd1);
        check_output("rd_und_cnt", 32'(n_und - b_und), 32'd0);
        check_output("rd_busy_end", 32'(busy_o), 32'd0);

        // Wrong address 0x23
        $display("[TB] write to non-matching 0x23");
        b_oe = n_oe; b_rx = rx_log.size(); b_stop = n_stop; b_hit = n_hit;
        bus_start();
        write_byte(8'h46, ack);
        check_output("na_addr_nack", 32'(ack), 32'd1);
        write_byte(8'h55, ack);
        check_output("na_data_nack", 32'(ack), 32'd1);
        bus_stop();
        repeat (10) @(negedge clk_i);
        check_output("na_oe_cnt", 32'(n_oe - b_oe), 32'd0);
        check_output("na_rx_cnt", 32'(rx_log.size() - b_rx), 32'd0);
        check_output("na_hit_cnt", 32'(n_hit - b_hit), 32'd0);
        check_output("na_stop_cnt", 32'(n_stop - b_stop), 32'd1);
        check_output("na_busy", 32'(busy_o), 32'd0);

        // Write 0x11, repeated START, read with empty tx source
        $display("[TB] write then repeated start read with underrun");
        b_start = n_start; b_rx = rx_log.size(); b_und = n_und;
        bus_start();
        write_byte(8'h44, ack);
        write_byte(8'h11, ack);
        check_output("rs_wr_ack", 32'(ack), 32'd0);
        bus_start();
        check_output("rs_busy", 32'(busy_o), 32'd1);
        write_byte(8'h45, ack);
        check_output("rs_rd_addr_ack", 32'(ack), 32'd0);
        read_byte(1'b1, rd);
        check_output("rs_rd_idle", 32'(rd), 32'hFF);
        bus_stop();
        repeat (10) @(negedge clk_i);
        check_output("rs_start_cnt", 32'(n_start - b_start), 32'd2);
        check_output("rs_rx_cnt", 32'(rx_log.size() - b_rx), 32'd1);
        check_output("rs_rx0", 32'(rx_log[b_rx]), 32'h11);
        check_output("rs_und_cnt", 32'(n_und - b_und), 32'd1);

        // STOP after 4 bits of a data byte, then a clean transaction
        $display("[TB] stop mid-byte");
        b_rx = rx_log.size(); b_stop = n_stop;
        bus_start();
        write_byte(8'h44, ack);
        for (int i = 0; i < 4; i++) bus_bit(i[0] ? 1'b0 : 1'b1, ack);
        bus_stop();
        repeat (10) @(negedge clk_i);
        check_output("ms_rx_cnt", 32'(rx_log.size() - b_rx), 32'd0);
        check_output("ms_stop_cnt", 32'(n_stop - b_stop), 32'd1);
        check_output("ms_busy", 32'(busy_o), 32'd0);
        bus_start();
        write_byte(8'h44, ack);
        write_byte(8'h5A, ack);
        check_output("ms_next_ack", 32'(ack), 32'd0);
        bus_stop();
        repeat (10) @(negedge clk_i);
        check_output("ms_next_rx", 32'(rx_log[rx_log.size()-1]), 32'h5A);

        // Reset while the responder is pulling SDA for read data
        $display("[TB] reset mid-read");
        tx_q.push_back(8'h00);
        b_ptr = tx_ptr;
        bus_start();
        write_byte(8'h45, ack);
        for (int i = 0; i < 200 && tx_ptr == b_ptr; i++) @(negedge clk_i);
        @(negedge clk_i);
        check_output("mr_tx_taken", 32'(tx_ptr - b_ptr), 32'd1);
        check_output("mr_driving", 32'(sda_oe_o), 32'd1);
        #2 rst_i = 1'b0;
        #1;
        check_output("mr_rst_oe", 32'(sda_oe_o), 32'd0);
        check_output("mr_rst_pulses", 32'({start_o, stop_o, addr_hit_o, rx_valid_o, tx_ready_o, underrun_o, mst_nack_o}), 32'd0);
        check_output("mr_rst_busy", 32'(busy_o), 32'd0);
        scl_m = 1'b1;
        sda_m = 1'b1;
        repeat (5) @(negedge clk_i);
        rst_i = 1'b1;
        repeat (5) @(negedge clk_i);
        bus_start();
        write_byte(8'h44, ack);
        check_output("mr_addr_ack", 32'(ack), 32'd0);
        write_byte(8'h42, ack);
        check_output("mr_data_ack", 32'(ack), 32'd0);
        bus_stop();
        repeat (10) @(negedge clk_i);
        check_output("mr_rx", 32'(rx_log[rx_log.size()-1]), 32'h42);

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule

// File: doc/i2c_slave_responder.md
Name: i2c_slave_responder

Overview:
- Synthesizable I2C target (responder) sitting on the bus opposite the i2cmb master DUT.
- Oversamples SCL/SDA on the system clock and detects START, repeated START and STOP.
- Matches a 7-bit address, delivers written bytes to the host side, and serves read bytes through a ready/valid handshake.
- Drives SDA open-drain only; never drives SCL and never clock-stretches. Serves as a self-checking bus partner and as a reusable IP.

Parameters:
SLAVE_ADDR, 7'h22, 7-bit address this responder ACKs
SYNC_STAGES, 2, synchronizer depth on scl_i/sda_i (legal range 2-3)
HOLD_CYCLES, 4, clk_i cycles after a detected SCL fall before sda_oe_o may change (legal range 1-15)
IDLE_BYTE, 8'hFF, byte shifted out on a read when no tx data is available

Ports:
clk_i  in  1  system clock
rst_i  in  1  reset, asynchronous, active-low
scl_i  in  1  bus SCL (resolved wire)
sda_i  in  1  bus SDA (resolved wire)
sda_oe_o  out  1  1 = pull SDA low, 0 = release
start_o  out  1  one-cycle pulse on START or repeated START
stop_o  out  1  one-cycle pulse on STOP
addr_hit_o  out  1  one-cycle pulse when the address matches; rw_o is valid with it
rw_o  out  1  1 = read transfer; held until the next START/STOP
rx_data_o  out  8  last written byte
rx_valid_o  out  1  one-cycle pulse; rx_data_o is valid
tx_data_i  in  8  next read byte
tx_valid_i  in  1  tx_data_i is valid
tx_ready_o  out  1  one-cycle pulse; tx_data_i consumed this cycle when tx_valid_i=1
underrun_o  out  1  one-cycle pulse; IDLE_BYTE was sent because tx_valid_i=0
mst_nack_o  out  1  one-cycle pulse; master NACKed a read byte
busy_o  out  1  high from START to STOP (any address)

Behaviour:
- Reset (rst_i=0, async): all outputs 0, rx_data_o=8'h00, state IDLE, synchronizer flops = 1 (bus-idle), counters 0.
- Synchronizer: SYNC_STAGES flops, then one delay flop for edge detection. Event latency from pin to internal event is SYNC_STAGES+1 cycles.
- Bus conditions:
  - START = SDA falls while SCL=1.
  - STOP = SDA rises while SCL=1.
  - Sampling occurs on SCL rise.
  - A START or STOP overrides any state, including mid-byte and the ACK slot; any partial byte is discarded.
- States: IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_LOAD, RD_BYTE, RD_ACK, IGNORE.
  - IDLE: wait for START -> ADDR (start_o, busy_o=1).
  - ADDR: shift 8 bits MSB first on SCL rises.
    - On the 8th bit, if bits[7:1]==SLAVE_ADDR -> ADDR_ACK with rw_o=bit0 and an addr_hit_o pulse.
    - Otherwise -> IGNORE.
  - ADDR_ACK: HOLD_CYCLES after the SCL fall, assert sda_oe_o.
    - On the next SCL fall, plus HOLD_CYCLES, release sda_oe_o.
    - Then go to WR_BYTE if rw_o=0, or RD_LOAD if rw_o=1.
  - WR_BYTE: shift 8 bits. On the 8th rise, update rx_data_o and pulse rx_valid_o in the same cycle, then go to WR_ACK (always ACK, same timing as ADDR_ACK), then WR_BYTE.
  - RD_LOAD: one cycle. Pulse tx_ready_o.
    - If tx_valid_i=1, load tx_data_i.
    - Otherwise load IDLE_BYTE and pulse underrun_o.
    - Then RD_BYTE. This occurs within the SCL-low period following the ACK.
  - RD_BYTE: drive bit7 first, sda_oe_o = ~bit, changed HOLD_CYCLES after each SCL fall. Release SDA HOLD_CYCLES after the 8th SCL fall, then RD_ACK.
  - RD_ACK: sample SDA on the SCL rise.
    - 0 -> RD_LOAD.
    - 1 -> pulse mst_nack_o and go to IGNORE.
  - IGNORE: sda_oe_o=0; wait for START (-> ADDR) or STOP (-> IDLE).
- STOP from any state: pulse stop_o, busy_o=0, rw_o=0, sda_oe_o=0 the same cycle, -> IDLE.
- Repeated START: pulse start_o, sda_oe_o=0, -> ADDR; busy_o stays 1.
- A START or STOP detected while sda_oe_o=1 (bus error) is handled identically: release immediately.
- Bit counter is 3 bits and wraps 7->0 at each byte boundary.
- The HOLD counter is restarted by every SCL fall.

Decomposition:
- typ_pkg: i2c_rsp_state_t enum, I2C_ADDR_W=7, I2C_DATA_W=8, i2c_op_t {WRITE=0, READ=1}.
- Sub-module i2c_line_sync: synchronizer, edge detect, and start/stop/scl_rise/scl_fall pulse generation (parameter SYNC_STAGES).

Test Plan:
- Write to 0x22 with bytes 0x00, 0x7F, 0xFF, then STOP:
  - addr_hit_o=1 with rw_o=0, ACK on all 4 slots.
  - rx_valid_o pulses 3 times carrying 00, 7F, FF.
  - stop_o pulses; busy_o falls.
- Read from 0x22 with tx queue 0xA5, 0x3C and master ACK then NACK:
  - Bus shows A5 then 3C.
  - tx_ready_o pulses twice; mst_nack_o pulses once; sda_oe_o=0 after.
- Address 0x23 write of 0x55:
  - No ACK (sda_oe_o never 1), no rx_valid_o; STOP -> IDLE.
- Write 0x22 byte 0x11, then repeated START, then read 0x22 with tx_valid_i=0:
  - start_o pulses twice, rx 0x11.
  - Bus reads 0xFF; underrun_o pulses.
- STOP injected after 4 bits of a write byte:
  - No rx_valid_o, stop_o pulses, state IDLE.
  - The next full transaction works normally.
- Reset asserted mid-read while sda_oe_o=1:
  - sda_oe_o=0 asynchronously, all pulse outputs 0.
  - After release, a write to 0x22 of 0x42 succeeds.
